// File: rtl/data_out32_ctrl_if.sv
// Bundle between the data-output controller and its neighbours: upstream block input,
// datapath PDI/st/DO side, and the serialized downstream word stream.
interface data_out32_ctrl_if #(
    parameter int WW     = 32,
    parameter int NWORDS = 8
);
    // Both streams use valid/ready: a transfer happens on a rising edge where valid and ready
    // are both 1; valid, once raised, holds its data stable until that transfer.
    logic                   in_valid;
    logic                   in_ready;
    logic [WW*NWORDS-1:0]   in_data;
    logic [WW*NWORDS-1:0]   PDI;
    logic [2:0]             st;
    logic [WW*NWORDS-1:0]   DO_bus;
    logic [WW-1:0]          dout;
    logic                   dout_valid;
    logic                   dout_ready;
    logic                   dout_last;
    logic                   busy;
    logic [1:0]             state;

    modport master (
        output in_valid, in_data, DO_bus, dout_ready,
        input  in_ready, PDI, st, dout, dout_valid, dout_last, busy, state
    );

    modport slave (
        input  in_valid, in_data, DO_bus, dout_ready,
        output in_ready, PDI, st, dout, dout_valid, dout_last, busy, state
    );
endinterface

// File: rtl/data_out32_ctrl.sv
// Sequencer/serializer for the 256-bit data-output datapath: holds a block on PDI, walks the
// stage select, captures the eight DO words and streams them out one word per handshake.
module data_out32_ctrl #(
    parameter int WW      = 32,
    parameter int NWORDS  = 8,
    parameter int ST_LAST = 5
) (
    input  logic              CLK,
    input  logic              rst,
    data_out32_ctrl_if.slave  bus
);
    localparam int IW = $clog2(NWORDS);
    localparam logic [2:0]    ST_END   = 3'(ST_LAST);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_SEND = 2'b10;

    logic [1:0]           state;
    logic [2:0]           st_q;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        idx_nxt;
    logic [WW*NWORDS-1:0] pdi_q;
    logic [WW-1:0]        words [NWORDS];
    logic [WW-1:0]        dout_q;
    logic                 dout_valid_q;
    logic                 dout_last_q;

    assign idx_nxt = idx + 1'b1;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state        <= S_IDLE;
            st_q         <= '0;
            idx          <= '0;
            pdi_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        pdi_q <= bus.in_data;
                        st_q  <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (st_q != ST_END) begin
                        st_q <= st_q + 3'd1;
                    end else begin
                        // Word 0 goes straight to the output register; the rest wait in words[].
                        idx          <= '0;
                        dout_q       <= bus.DO_bus[WW-1:0];
                        dout_valid_q <= 1'b1;
                        dout_last_q  <= (LAST_IDX == '0);
                        state        <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.dout_ready) begin
                        if (idx != LAST_IDX) begin
                            idx         <= idx_nxt;
                            dout_q      <= words[idx_nxt];
                            dout_last_q <= (idx_nxt == LAST_IDX);
                        end else begin
                            dout_valid_q <= 1'b0;
                            dout_last_q  <= 1'b0;
                            st_q         <= '0;
                            state        <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Capture register has no reset: it is only read after a capture has written it.
    always_ff @(posedge CLK) begin
        if (!rst && state == S_RUN && st_q == ST_END) begin
            for (int i = 0; i < NWORDS; i++) begin
                words[i] <= bus.DO_bus[i*WW +: WW];
            end
        end
    end

    assign bus.in_ready   = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.st         = st_q;
    assign bus.PDI        = pdi_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_last  = dout_last_q;
    assign bus.state      = state;
endmodule

// File: tb/tb_data_out32_ctrl.sv
// Bench for data_out32_ctrl: scenario tasks drive blocks; a negedge scoreboard pops the
// expected {last, word} pairs on every output handshake.
module tb_data_out32_ctrl;
    logic CLK = 1'b0;
    logic rst = 1'b1;

    data_out32_ctrl_if bus ();

    data_out32_ctrl dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Datapath model: every DO word is the inverted PDI word.
    assign bus.DO_bus = ~bus.PDI;

    int          tests  = 0;
    int          fails  = 0;
    int          hs_cnt = 0;
    logic [32:0] exp_q[$];

    always @(negedge CLK) begin
        if (!rst && bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected got last=%b dout=%h want no word", bus.dout_last, bus.dout);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({bus.dout_last, bus.dout} !== e) begin
                    fails++;
                    $display("FAIL sb_word got last=%b dout=%h want last=%b dout=%h",
                             bus.dout_last, bus.dout, e[32], e[31:0]);
                end
            end
            hs_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [255:0] rand_block();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    task automatic push_block(input logic [255:0] d);
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), ~d[32*i +: 32]});
    endtask

    // Present a block until accepted; returns one time unit after the accept edge.
    task automatic send_block(input logic [255:0] d, output bit ok);
        ok = 1'b0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 40 && !ok; c++) begin
            if (bus.in_ready === 1'b1) begin
                push_block(d);
                ok = 1'b1;
            end
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) tick();
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = rand_block();
        bus.dout_ready = 1'b0;
        tick();
        tick();
        tests++;
        if ({bus.in_ready, bus.busy, bus.dout_valid, bus.dout_last} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_flags got rdy/busy/dv/dl=%b want 1000",
                     {bus.in_ready, bus.busy, bus.dout_valid, bus.dout_last});
        end
        tests++;
        if (bus.st !== 3'd0) begin fails++; $display("FAIL reset_st got %0d want 0", bus.st); end
        tests++;
        if (bus.PDI !== 256'd0) begin fails++; $display("FAIL reset_pdi got %h want 0", bus.PDI); end
        tests++;
        if (bus.dout !== 32'd0) begin fails++; $display("FAIL reset_dout got %h want 0", bus.dout); end
        bus.in_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        logic [255:0] d;
        bit ok;
        int h0;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = 32'hA5A5_0000 + i;
        bus.dout_ready = 1'b1;
        h0 = hs_cnt;
        send_block(d, ok);
        tests++;
        if (!ok || bus.st !== 3'd0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL nom_accept got ok=%b st=%0d busy=%b want 1 0 1", ok, bus.st, bus.busy);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests++;
            if (bus.st !== 3'(k) || bus.dout_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL nom_st got st=%0d dv=%b rdy=%b want st=%0d dv=0 rdy=0",
                         bus.st, bus.dout_valid, bus.in_ready, k);
            end
        end
        tick();
        tests++;
        if (bus.dout_valid !== 1'b1 || bus.st !== 3'd5) begin
            fails++;
            $display("FAIL nom_latency got dv=%b st=%0d want dv=1 st=5", bus.dout_valid, bus.st);
        end
        for (int k = 0; k < 8; k++) tick();
        tests++;
        if (bus.in_ready !== 1'b1 || bus.dout_valid !== 1'b0 || bus.st !== 3'd0) begin
            fails++;
            $display("FAIL nom_done got rdy=%b dv=%b st=%0d want 1 0 0", bus.in_ready, bus.dout_valid, bus.st);
        end
        tests++;
        if (hs_cnt - h0 != 8 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL nom_count got hs=%0d left=%0d want 8 0", hs_cnt - h0, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int h0, s2, s7, done;
        s2 = 0;
        s7 = 0;
        bus.dout_ready = 1'b1;
        h0 = hs_cnt;
        send_block(rand_block(), ok);
        for (int k = 0; k < 6; k++) tick();
        for (int c = 0; c < 40 && (hs_cnt - h0) < 8; c++) begin
            done = hs_cnt - h0;
            tests++;
            if (exp_q.size() == 0 || bus.dout_valid !== 1'b1 || {bus.dout_last, bus.dout} !== exp_q[0]) begin
                fails++;
                $display("FAIL bp_hold got dv=%b last=%b dout=%h after %0d words", bus.dout_valid,
                         bus.dout_last, bus.dout, done);
            end
            if (done == 2 && s2 < 3) begin
                bus.dout_ready = 1'b0;
                s2++;
            end else if (done == 7 && s7 < 1) begin
                bus.dout_ready = 1'b0;
                s7++;
            end else begin
                bus.dout_ready = 1'b1;
            end
            tick();
        end
        bus.dout_ready = 1'b1;
        tick();
        tests++;
        if (hs_cnt - h0 != 8 || s2 != 3 || s7 != 1 || exp_q.size() != 0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_count got hs=%0d s2=%0d s7=%0d left=%0d busy=%b want 8 3 1 0 0",
                     hs_cnt - h0, s2, s7, exp_q.size(), bus.busy);
        end
    endtask

    task automatic test_busy_input();
        logic [255:0] a, b;
        bit ok1, ok2, ok3;
        int h0;
        a = rand_block();
        b = rand_block();
        bus.dout_ready = 1'b1;
        h0 = hs_cnt;
        send_block(a, ok1);
        tick();
        tick();
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        tests++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL busy_rdy_run got %b want 0", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.PDI !== a) begin fails++; $display("FAIL busy_pdi_run got %h want %h", bus.PDI, a); end
        for (int k = 0; k < 4; k++) tick();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.PDI !== a || bus.dout_valid !== 1'b1) begin
            fails++;
            $display("FAIL busy_pdi_send got pdi=%h dv=%b want %h 1", bus.PDI, bus.dout_valid, a);
        end
        drain(30, ok2);
        tests++;
        if (!ok2 || bus.busy !== 1'b0 || bus.PDI !== a) begin
            fails++;
            $display("FAIL busy_first got ok=%b busy=%b pdi=%h want 1 0 %h", ok2, bus.busy, bus.PDI, a);
        end
        send_block(b, ok3);
        tests++;
        if (!ok3 || bus.PDI !== b) begin fails++; $display("FAIL busy_second got pdi=%h want %h", bus.PDI, b); end
        drain(30, ok2);
        tests++;
        if (!ok1 || !ok2 || hs_cnt - h0 != 16) begin
            fails++;
            $display("FAIL busy_count got hs=%0d want 16", hs_cnt - h0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int h0;
        bus.dout_ready = 1'b1;
        send_block(rand_block(), ok);
        for (int k = 0; k < 3; k++) tick();
        tests++;
        if (bus.st !== 3'd3) begin fails++; $display("FAIL rmid_st got %0d want 3", bus.st); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        tests++;
        if ({bus.busy, bus.dout_valid, bus.in_ready} !== 3'b001 || bus.st !== 3'd0) begin
            fails++;
            $display("FAIL rmid_run got busy/dv/rdy=%b st=%0d want 001 0",
                     {bus.busy, bus.dout_valid, bus.in_ready}, bus.st);
        end
        h0 = hs_cnt;
        send_block(rand_block(), ok);
        for (int c = 0; c < 30 && (hs_cnt - h0) < 4; c++) tick();
        tests++;
        if (hs_cnt - h0 != 4 || exp_q.size() == 0 || bus.dout !== exp_q[0][31:0]) begin
            fails++;
            $display("FAIL rmid_idx4 got hs=%0d dout=%h", hs_cnt - h0, bus.dout);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        tests++;
        if ({bus.busy, bus.dout_valid, bus.dout_last, bus.in_ready} !== 4'b0001 || bus.st !== 3'd0) begin
            fails++;
            $display("FAIL rmid_send got busy/dv/dl/rdy=%b st=%0d want 0001 0",
                     {bus.busy, bus.dout_valid, bus.dout_last, bus.in_ready}, bus.st);
        end
        h0 = hs_cnt;
        send_block(rand_block(), ok);
        drain(30, ok);
        tests++;
        if (!ok || hs_cnt - h0 != 8) begin
            fails++;
            $display("FAIL rmid_clean got ok=%b hs=%0d want 1 8", ok, hs_cnt - h0);
        end
    endtask

    task automatic test_back_to_back();
        int acc[3];
        int n, cyc, h0;
        bit ok;
        n = 0;
        cyc = 0;
        h0 = hs_cnt;
        bus.dout_ready = 1'b1;
        bus.in_data    = rand_block();
        bus.in_valid   = 1'b1;
        while (n < 3 && cyc < 200) begin
            if (bus.in_ready === 1'b1) begin
                push_block(bus.in_data);
                acc[n] = cyc;
                n++;
                tick();
                bus.in_data = rand_block();
                if (n == 3) bus.in_valid = 1'b0;
            end else begin
                tick();
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        drain(60, ok);
        tests++;
        if (n != 3 || acc[1] - acc[0] != 15 || acc[2] - acc[1] != 15) begin
            fails++;
            $display("FAIL b2b_period got n=%0d p1=%0d p2=%0d want 3 15 15", n, acc[1] - acc[0], acc[2] - acc[1]);
        end
        tests++;
        if (!ok || hs_cnt - h0 != 24) begin
            fails++;
            $display("FAIL b2b_count got ok=%b hs=%0d want 1 24", ok, hs_cnt - h0);
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.dout_ready = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_busy_input();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
